// File: rtl/timer_regs_pkg.sv
// Shared definitions for the bus_timer slave: register offsets, control bit
// position, bus FSM states and the byte-lane write merge helper.
`timescale 1ns/1ps
package timer_regs_pkg;

  localparam logic [31:0] TMR_MTIME_LO = 32'h00;
  localparam logic [31:0] TMR_MTIME_HI = 32'h04;
  localparam logic [31:0] TMR_CMP_LO   = 32'h08;
  localparam logic [31:0] TMR_CMP_HI   = 32'h0C;
  localparam logic [31:0] TMR_CTRL     = 32'h10;
  localparam logic [31:0] TMR_PRESCALE = 32'h14;

  localparam int unsigned CTRL_EN_BIT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider for bus_timer: tick fires when the count equals the divisor,
// then the count restarts. Held at zero while disabled or on clear.
`timescale 1ns/1ps
module timer_prescaler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] divisor,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  assign tick = en && (count == divisor);

  // Holding zero while disabled makes every 0->1 enable start a fresh period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!en || clr || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 64-bit machine timer slave with registered compare interrupt.
// Optional tick prescaler enabled by defining TIMER_PRESCALER_EN.
`timescale 1ns/1ps
module bus_timer
  import timer_regs_pkg::*;
#(
  parameter int unsigned OFFSET_BITS    = 14,
  parameter logic [63:0] CMP_RESET      = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_write,
  input  logic        s_enable,
  output logic [31:0] s_rdata,
  output logic        s_ready,
  output logic        timer_irq
);

  bus_state_t  state, state_next;
  logic [31:0] off;
  logic        accept, wr_en, rd_en;
  logic        tick;

  logic [63:0] mtime, mtime_next;
  logic [63:0] mtime_cmp, cmp_next;
  logic        ctrl_en, en_next;
  logic        irq_next;
  logic [31:0] rd_val;

  logic unused_addr;
  assign unused_addr = ^{s_addr[31:OFFSET_BITS], s_addr[1:0]};

  always_comb begin
    off = '0;
    off[OFFSET_BITS-1:2] = s_addr[OFFSET_BITS-1:2];
  end

  assign accept = (state == IDLE) && s_enable;
  assign wr_en  = accept && s_write;
  assign rd_en  = accept && !s_write;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (s_enable) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign s_ready = (state == RESP);

`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      wr_prescale;

  assign wr_prescale = wr_en && (off == TMR_PRESCALE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              prescale <= '0;
    else if (wr_prescale) prescale <= PRESCALE_WIDTH'(merge_bytes(32'(prescale), s_wdata, s_wstrb));
  end

  timer_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (ctrl_en),
    .clr     (wr_prescale),
    .divisor (prescale),
    .tick    (tick)
  );
`else
  logic unused_width;
  assign unused_width = (PRESCALE_WIDTH == 0);
  assign tick = 1'b1;
`endif

  // A bus write to either mtime half suppresses the increment for the whole counter.
  always_comb begin
    mtime_next = mtime;
    cmp_next   = mtime_cmp;
    en_next    = ctrl_en;
    if (wr_en && off == TMR_MTIME_LO) begin
      mtime_next[31:0] = merge_bytes(mtime[31:0], s_wdata, s_wstrb);
    end else if (wr_en && off == TMR_MTIME_HI) begin
      mtime_next[63:32] = merge_bytes(mtime[63:32], s_wdata, s_wstrb);
    end else if (ctrl_en && tick) begin
      mtime_next = mtime + 64'd1;
    end
    if (wr_en && off == TMR_CMP_LO) cmp_next[31:0]  = merge_bytes(mtime_cmp[31:0], s_wdata, s_wstrb);
    if (wr_en && off == TMR_CMP_HI) cmp_next[63:32] = merge_bytes(mtime_cmp[63:32], s_wdata, s_wstrb);
    if (wr_en && off == TMR_CTRL && s_wstrb[CTRL_EN_BIT/8]) en_next = s_wdata[CTRL_EN_BIT];
  end

  assign irq_next = en_next && (mtime_next >= cmp_next);

  always_comb begin
    rd_val = '0;
    case (off)
      TMR_MTIME_LO: rd_val = mtime[31:0];
      TMR_MTIME_HI: rd_val = mtime[63:32];
      TMR_CMP_LO:   rd_val = mtime_cmp[31:0];
      TMR_CMP_HI:   rd_val = mtime_cmp[63:32];
      TMR_CTRL:     rd_val[CTRL_EN_BIT] = ctrl_en;
`ifdef TIMER_PRESCALER_EN
      TMR_PRESCALE: rd_val[PRESCALE_WIDTH-1:0] = prescale;
`endif
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime     <= '0;
      mtime_cmp <= CMP_RESET;
      ctrl_en   <= 1'b0;
      timer_irq <= 1'b0;
      s_rdata   <= '0;
    end else begin
      mtime     <= mtime_next;
      mtime_cmp <= cmp_next;
      ctrl_en   <= en_next;
      timer_irq <= irq_next;
      if (rd_en) s_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Randomised self-checking bench for bus_timer against a time-based reference
// model (mtime expressed as anchor value plus elapsed tick count).
`timescale 1ns/1ps
module tb_bus_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_write, s_enable, s_ready, timer_irq;

  bus_timer #(
    .OFFSET_BITS    (14),
    .CMP_RESET      (64'hFFFF_FFFF_FFFF_FFFF),
    .PRESCALE_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_write   (s_write),
    .s_enable  (s_enable),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: mtime after edge k = m_val + ticks in edges (m_k, k];
  // ticks fall on edges k where (k - m_d) is a multiple of (m_p + 1).
  logic [63:0]     m_val, m_cmp;
  logic            m_en;
  longint unsigned m_k, m_d, m_p;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] st);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = st[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mt_at(input longint unsigned k);
    if (!m_en) return m_val;
    return m_val + 64'((k - m_d) / (m_p + 1)) - 64'((m_k - m_d) / (m_p + 1));
  endfunction

  function automatic logic model_irq(input longint unsigned k);
    return m_en && (mt_at(k) >= m_cmp);
  endfunction

  task automatic model_reset();
    m_val = '0; m_cmp = '1; m_en = 1'b0; m_p = 0; m_k = cyc; m_d = cyc;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input longint unsigned k);
    logic [63:0] pre;
    logic [13:0] o;
    pre = mt_at(k - 1);
    o = a[13:0] & 14'h3FFC;
    case (o)
      14'h00:  return pre[31:0];
      14'h04:  return pre[63:32];
      14'h08:  return m_cmp[31:0];
      14'h0C:  return m_cmp[63:32];
      14'h10:  return {31'd0, m_en};
`ifdef TIMER_PRESCALER_EN
      14'h14:  return m_p[31:0];
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             input longint unsigned k);
    logic [63:0] pre, v;
    logic [13:0] o;
    logic [31:0] p32;
    pre = mt_at(k - 1);
    v   = mt_at(k);
    o   = a[13:0] & 14'h3FFC;
    case (o)
      14'h00: begin m_val = {pre[63:32], mrg(pre[31:0], d, st)}; m_k = k; end
      14'h04: begin m_val = {mrg(pre[63:32], d, st), pre[31:0]}; m_k = k; end
      14'h08: m_cmp[31:0]  = mrg(m_cmp[31:0], d, st);
      14'h0C: m_cmp[63:32] = mrg(m_cmp[63:32], d, st);
      14'h10: if (st[0]) begin
        if (d[0] && !m_en) m_d = k;
        m_val = v; m_k = k; m_en = d[0];
      end
`ifdef TIMER_PRESCALER_EN
      14'h14: begin
        p32 = mrg(m_p[31:0], d, st);
        m_val = v; m_k = k; m_d = k; m_p = longint'(p32[15:0]);
      end
`endif
      default: ;
    endcase
  endtask

  task automatic bus_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st, output logic [31:0] rd);
    logic [31:0] exp_rd;
    s_addr = a; s_wdata = d; s_wstrb = st; s_write = wr; s_enable = 1'b1;
    @(posedge clk); #1;
    exp_rd = model_read(a, cyc);
    if (wr) model_write(a, d, st, cyc);
    s_enable = 1'b0;
    check("ready_pulse", s_ready, 1'b1);
    if (!wr) check($sformatf("rdata@%h", a[13:0]), s_rdata, exp_rd);
    check("irq", timer_irq, model_irq(cyc));
    rd = s_rdata;
    @(posedge clk); #1;
    check("ready_drop", s_ready, 1'b0);
    check("irq", timer_irq, model_irq(cyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("irq_idle", timer_irq, model_irq(cyc));
    end
  endtask

  localparam logic [31:0] BASE = 32'h4000_4000;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] offs [8];
    int          pulses;
    logic [31:0] a, d;
    offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20, 32'h3FFC};

    rst = 1'b1; s_addr = '0; s_wdata = '0; s_wstrb = '0; s_write = 1'b0; s_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", s_ready, 1'b0);
    check("rst_irq", timer_irq, 1'b0);
    check("rst_rdata", s_rdata, 32'd0);
    rst = 1'b0;
    model_reset();

    // Reset values of all six registers
    for (int i = 0; i < 6; i++) bus_op(1'b0, BASE | offs[i], 32'd0, 4'h0, rd);
    bus_op(1'b0, BASE | 32'h8, 32'd0, 4'h0, rd);
    check("cmp_lo_reset_const", rd, 32'hFFFF_FFFF);

    // Compare at 0x10, enable, watch irq rise
    bus_op(1'b1, BASE | 32'hC, 32'h0, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h8, 32'h10, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h10, 32'h1, 4'hF, rd);
    idle(25);

    // 64-bit wrap
    bus_op(1'b1, BASE | 32'h10, 32'h0, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h0, 32'hFFFF_FFFF, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h4, 32'hFFFF_FFFF, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h8, 32'h100, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h10, 32'h1, 4'hF, rd);
    idle(3);
    bus_op(1'b0, BASE | 32'h4, 32'd0, 4'h0, rd);
    check("wrap_hi_const", rd, 32'd0);
    bus_op(1'b0, BASE | 32'h0, 32'd0, 4'h0, rd);

    // Single byte-lane write
    bus_op(1'b1, BASE | 32'h8, 32'hFFFF_FFFF, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h8, 32'hAABB_CCDD, 4'b0010, rd);
    bus_op(1'b0, BASE | 32'h8, 32'd0, 4'h0, rd);
    check("wstrb_merge_const", rd, 32'hFFFF_CCFF);

    // Enable held high for 4 cycles on an unmapped offset
    s_addr = BASE | 32'h20; s_write = 1'b0; s_wstrb = 4'h0; s_enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (s_ready) pulses++;
      check($sformatf("held_ready_%0d", i), s_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
      if (i % 2 == 0) check("unmapped_rdata", s_rdata, 32'd0);
      check("irq", timer_irq, model_irq(cyc));
    end
    s_enable = 1'b0;
    check("held_pulse_count", 64'(pulses), 64'd2);
    idle(1);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      a = BASE | offs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      d = $urandom;
      if ((a[13:0] & 14'h3FFC) == 14'h10) d = 32'($urandom_range(0, 3) != 0);
      if ((a[13:0] & 14'h3FFC) == 14'h14) d = 32'($urandom_range(0, 4));
      if ((a[13:0] & 14'h3FFC) == 14'h0C) d = 32'($urandom_range(0, 1));
      if ((a[13:0] & 14'h3FFC) == 14'h04) d = 32'($urandom_range(0, 1));
      bus_op(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), rd);
      idle($urandom_range(0, 3));
    end

    // Prescaled count over 40 enabled cycles
    bus_op(1'b1, BASE | 32'h10, 32'h0, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h0, 32'h0, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h4, 32'h0, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h14, 32'h3, 4'hF, rd);
    bus_op(1'b1, BASE | 32'h10, 32'h1, 4'hF, rd);
    idle(39);
    bus_op(1'b0, BASE | 32'h0, 32'd0, 4'h0, rd);
`ifdef TIMER_PRESCALER_EN
    check("prescaled_count", rd, 32'd10);
`else
    check("unscaled_count", rd, 32'd40);
`endif
    bus_op(1'b0, BASE | 32'h14, 32'd0, 4'h0, rd);

    // Reset during a response cycle
    bus_op(1'b1, BASE | 32'h8, 32'h0, 4'hF, rd);
    bus_op(1'b1, BASE | 32'hC, 32'h0, 4'hF, rd);
    check("irq_before_reset", timer_irq, 1'b1);
    s_addr = BASE | 32'h10; s_write = 1'b0; s_enable = 1'b1;
    @(posedge clk); #1;
    s_enable = 1'b0;
    check("ready_before_reset", s_ready, 1'b1);
    rst = 1'b1;
    #1;
    check("ready_async_reset", s_ready, 1'b0);
    check("irq_async_reset", timer_irq, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    bus_op(1'b0, BASE | 32'h10, 32'd0, 4'h0, rd);
    bus_op(1'b0, BASE | 32'hC, 32'd0, 4'h0, rd);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
